// File: rtl/nasti_lite_write_slave.sv
// NASTI-lite write-channel terminator.
// Joins independently arriving lite AW and W beats (one holding entry each), issues a single
// register write per AW/W pair, and returns one B response per pair.
//
// Ports:
//   clk, rstn               clock, synchronous active-low reset
//   lite_aw_*               write address channel (prot/qos/region accepted but unused)
//   lite_w_*                write data channel (user accepted but unused)
//   lite_b_*                write response channel; id/user echo the AW beat
//   reg_wr_valid/ready      register write handshake towards the peripheral bank
//   reg_wr_addr/data/strb   byte offset from ADDR_BASE, held W data and strobes
//   reg_wr_err              sampled with reg_wr_ready; 1 turns the response into SLVERR
module nasti_lite_write_slave #(
  parameter int unsigned ID_WIDTH        = 1,
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned LITE_DATA_WIDTH = 32,
  parameter int unsigned USER_WIDTH      = 1,
  parameter int unsigned ADDR_BASE       = 0,
  parameter int unsigned ADDR_SIZE       = 256
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [ID_WIDTH-1:0]          lite_aw_id,
  input  logic [ADDR_WIDTH-1:0]        lite_aw_addr,
  input  logic [2:0]                   lite_aw_prot,
  input  logic [3:0]                   lite_aw_qos,
  input  logic [3:0]                   lite_aw_region,
  input  logic [USER_WIDTH-1:0]        lite_aw_user,
  input  logic                         lite_aw_valid,
  output logic                         lite_aw_ready,
  input  logic [LITE_DATA_WIDTH-1:0]   lite_w_data,
  input  logic [LITE_DATA_WIDTH/8-1:0] lite_w_strb,
  input  logic [USER_WIDTH-1:0]        lite_w_user,
  input  logic                         lite_w_valid,
  output logic                         lite_w_ready,
  output logic [ID_WIDTH-1:0]          lite_b_id,
  output logic [1:0]                   lite_b_resp,
  output logic [USER_WIDTH-1:0]        lite_b_user,
  output logic                         lite_b_valid,
  input  logic                         lite_b_ready,
  output logic                         reg_wr_valid,
  input  logic                         reg_wr_ready,
  output logic [ADDR_WIDTH-1:0]        reg_wr_addr,
  output logic [LITE_DATA_WIDTH-1:0]   reg_wr_data,
  output logic [LITE_DATA_WIDTH/8-1:0] reg_wr_strb,
  input  logic                         reg_wr_err
);

  localparam int unsigned STRB_WIDTH  = LITE_DATA_WIDTH / 8;
  localparam int unsigned LITE_W_BITS = $clog2(STRB_WIDTH);
  localparam int unsigned EXT_WIDTH   = ADDR_WIDTH + 1;

  // Range bounds carry one extra bit so base+size never wraps into the window.
  localparam logic [ADDR_WIDTH:0]   BASE_EXT  = EXT_WIDTH'(ADDR_BASE);
  localparam logic [ADDR_WIDTH:0]   LIMIT_EXT = EXT_WIDTH'(ADDR_BASE + ADDR_SIZE);
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(ADDR_BASE);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  if (LITE_DATA_WIDTH != 32 && LITE_DATA_WIDTH != 64) begin : g_bad_data_width
    $fatal(1, "LITE_DATA_WIDTH must be 32 or 64");
  end
  if (ADDR_SIZE == 0) begin : g_bad_addr_size
    $fatal(1, "ADDR_SIZE must be greater than zero");
  end
  if (USER_WIDTH == 0) begin : g_bad_user_width
    $fatal(1, "USER_WIDTH must be greater than zero");
  end

  typedef enum logic [1:0] {StIdle, StWrite, StResp} state_e;

  state_e                 state_q, state_d;
  logic                   aw_held_q, w_held_q;
  logic [ID_WIDTH-1:0]    aw_id_q;
  logic [ADDR_WIDTH-1:0]  aw_addr_q;
  logic [USER_WIDTH-1:0]  aw_user_q;
  logic [LITE_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0]  w_strb_q;
  // B payload gets its own copy so the AW hold can take the next beat while B is pending.
  logic [ID_WIDTH-1:0]    b_id_q;
  logic [USER_WIDTH-1:0]  b_user_q;
  logic [1:0]             resp_q, resp_d;

  logic aw_fire, w_fire, b_load;
  logic [ADDR_WIDTH:0] addr_ext;
  logic in_range, misaligned;
  logic [1:0] decode_resp;

  assign lite_aw_ready = ~aw_held_q;
  assign lite_w_ready  = ~w_held_q;
  assign aw_fire       = lite_aw_valid & ~aw_held_q;
  assign w_fire        = lite_w_valid & ~w_held_q;

  assign addr_ext    = {1'b0, aw_addr_q};
  assign in_range    = (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
  assign misaligned  = |aw_addr_q[LITE_W_BITS-1:0];
  // Out-of-window wins over misalignment.
  assign decode_resp = !in_range ? RESP_DECERR : (misaligned ? RESP_SLVERR : RESP_OKAY);

  always_comb begin
    state_d      = state_q;
    resp_d       = resp_q;
    b_load       = 1'b0;
    reg_wr_valid = 1'b0;
    lite_b_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (aw_held_q && w_held_q) begin
          if (decode_resp == RESP_OKAY) begin
            state_d = StWrite;
          end else begin
            state_d = StResp;
            resp_d  = decode_resp;
            b_load  = 1'b1;
          end
        end
      end
      StWrite: begin
        reg_wr_valid = 1'b1;
        if (reg_wr_ready) begin
          state_d = StResp;
          resp_d  = reg_wr_err ? RESP_SLVERR : RESP_OKAY;
          b_load  = 1'b1;
        end
      end
      StResp: begin
        lite_b_valid = 1'b1;
        if (lite_b_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      resp_q    <= RESP_OKAY;
      aw_id_q   <= '0;
      aw_addr_q <= '0;
      aw_user_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_id_q    <= '0;
      b_user_q  <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      // b_load only fires with both holds set, so it never collides with a new accept.
      if (b_load) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        b_id_q    <= aw_id_q;
        b_user_q  <= aw_user_q;
      end else begin
        if (aw_fire) aw_held_q <= 1'b1;
        if (w_fire)  w_held_q  <= 1'b1;
      end
      if (aw_fire) begin
        aw_id_q   <= lite_aw_id;
        aw_addr_q <= lite_aw_addr;
        aw_user_q <= lite_aw_user;
      end
      if (w_fire) begin
        w_data_q <= lite_w_data;
        w_strb_q <= lite_w_strb;
      end
    end
  end

  assign lite_b_id   = b_id_q;
  assign lite_b_user = b_user_q;
  assign lite_b_resp = resp_q;
  assign reg_wr_addr = aw_addr_q - BASE_ADDR;
  assign reg_wr_data = w_data_q;
  assign reg_wr_strb = w_strb_q;

  logic unused_inputs;
  assign unused_inputs = ^{lite_aw_prot, lite_aw_qos, lite_aw_region, lite_w_user};

endmodule

// File: tb/tb_nasti_lite_write_slave.sv
// Directed bench for nasti_lite_write_slave. Instance dut uses the default full window,
// dut_dec a 0x40..0x4F window; sel steers handshakes and observed outputs between them.
module tb_nasti_lite_write_slave;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sel = 1'b0;
  logic [0:0]  lite_aw_id = '0;
  logic [7:0]  lite_aw_addr = '0;
  logic [2:0]  lite_aw_prot = '0;
  logic [3:0]  lite_aw_qos = '0;
  logic [3:0]  lite_aw_region = '0;
  logic [0:0]  lite_aw_user = '0;
  logic        lite_aw_valid = 1'b0;
  logic [31:0] lite_w_data = '0;
  logic [3:0]  lite_w_strb = '0;
  logic [0:0]  lite_w_user = '0;
  logic        lite_w_valid = 1'b0;
  logic        lite_b_ready = 1'b0;
  logic        rw_ready = 1'b0;
  logic        rw_err = 1'b0;

  logic d0_aw_ready, d0_w_ready, d0_b_valid, d0_rw_valid;
  logic d1_aw_ready, d1_w_ready, d1_b_valid, d1_rw_valid;
  logic [0:0] d0_b_id, d1_b_id, d0_b_user, d1_b_user;
  logic [1:0] d0_b_resp, d1_b_resp;
  logic [7:0] d0_rw_addr, d1_rw_addr;
  logic [31:0] d0_rw_data, d1_rw_data;
  logic [3:0] d0_rw_strb, d1_rw_strb;

  logic o_aw_ready, o_w_ready, o_b_valid, o_rw_valid;
  logic [0:0] o_b_id, o_b_user;
  logic [1:0] o_b_resp;
  logic [7:0] o_rw_addr;
  logic [31:0] o_rw_data;
  logic [3:0] o_rw_strb;

  assign o_aw_ready = sel ? d1_aw_ready : d0_aw_ready;
  assign o_w_ready  = sel ? d1_w_ready  : d0_w_ready;
  assign o_b_valid  = sel ? d1_b_valid  : d0_b_valid;
  assign o_rw_valid = sel ? d1_rw_valid : d0_rw_valid;
  assign o_b_id     = sel ? d1_b_id     : d0_b_id;
  assign o_b_user   = sel ? d1_b_user   : d0_b_user;
  assign o_b_resp   = sel ? d1_b_resp   : d0_b_resp;
  assign o_rw_addr  = sel ? d1_rw_addr  : d0_rw_addr;
  assign o_rw_data  = sel ? d1_rw_data  : d0_rw_data;
  assign o_rw_strb  = sel ? d1_rw_strb  : d0_rw_strb;

  nasti_lite_write_slave dut (
    .clk(clk), .rstn(rstn),
    .lite_aw_id(lite_aw_id), .lite_aw_addr(lite_aw_addr), .lite_aw_prot(lite_aw_prot),
    .lite_aw_qos(lite_aw_qos), .lite_aw_region(lite_aw_region), .lite_aw_user(lite_aw_user),
    .lite_aw_valid(lite_aw_valid & ~sel), .lite_aw_ready(d0_aw_ready),
    .lite_w_data(lite_w_data), .lite_w_strb(lite_w_strb), .lite_w_user(lite_w_user),
    .lite_w_valid(lite_w_valid & ~sel), .lite_w_ready(d0_w_ready),
    .lite_b_id(d0_b_id), .lite_b_resp(d0_b_resp), .lite_b_user(d0_b_user),
    .lite_b_valid(d0_b_valid), .lite_b_ready(lite_b_ready & ~sel),
    .reg_wr_valid(d0_rw_valid), .reg_wr_ready(rw_ready & ~sel), .reg_wr_addr(d0_rw_addr),
    .reg_wr_data(d0_rw_data), .reg_wr_strb(d0_rw_strb), .reg_wr_err(rw_err)
  );

  nasti_lite_write_slave #(.ADDR_BASE(32'h40), .ADDR_SIZE(32'h10)) dut_dec (
    .clk(clk), .rstn(rstn),
    .lite_aw_id(lite_aw_id), .lite_aw_addr(lite_aw_addr), .lite_aw_prot(lite_aw_prot),
    .lite_aw_qos(lite_aw_qos), .lite_aw_region(lite_aw_region), .lite_aw_user(lite_aw_user),
    .lite_aw_valid(lite_aw_valid & sel), .lite_aw_ready(d1_aw_ready),
    .lite_w_data(lite_w_data), .lite_w_strb(lite_w_strb), .lite_w_user(lite_w_user),
    .lite_w_valid(lite_w_valid & sel), .lite_w_ready(d1_w_ready),
    .lite_b_id(d1_b_id), .lite_b_resp(d1_b_resp), .lite_b_user(d1_b_user),
    .lite_b_valid(d1_b_valid), .lite_b_ready(lite_b_ready & sel),
    .reg_wr_valid(d1_rw_valid), .reg_wr_ready(rw_ready & sel), .reg_wr_addr(d1_rw_addr),
    .reg_wr_data(d1_rw_data), .reg_wr_strb(d1_rw_strb), .reg_wr_err(rw_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Drives AW and/or W (values held until accepted), bounded to 20 cycles.
  task automatic issue(input bit en_aw, input bit en_w, input logic [0:0] id,
                       input logic [7:0] addr, input logic [0:0] user,
                       input logic [31:0] data, input logic [3:0] strb, output bit ok);
    bit aw_done, w_done, ra, rw;
    @(posedge clk); #1;
    aw_done = !en_aw;
    w_done  = !en_w;
    if (en_aw) begin
      lite_aw_id = id; lite_aw_addr = addr; lite_aw_user = user; lite_aw_valid = 1'b1;
    end
    if (en_w) begin
      lite_w_data = data; lite_w_strb = strb; lite_w_valid = 1'b1;
    end
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      @(negedge clk);
      ra = lite_aw_valid && o_aw_ready;
      rw = lite_w_valid && o_w_ready;
      @(posedge clk); #1;
      if (ra) begin aw_done = 1'b1; lite_aw_valid = 1'b0; end
      if (rw) begin w_done = 1'b1; lite_w_valid = 1'b0; end
    end
    lite_aw_valid = 1'b0;
    lite_w_valid  = 1'b0;
    ok = aw_done && w_done;
  endtask

  // Counts register-write and B handshakes over a window and captures their payloads.
  task automatic observe(input int cycles, output int n_wr, output int n_b,
                         output logic [7:0] wa, output logic [31:0] wd, output logic [3:0] ws,
                         output logic [1:0] br, output logic [0:0] bid, output logic [0:0] bu);
    n_wr = 0; n_b = 0; wa = '0; wd = '0; ws = '0; br = '0; bid = '0; bu = '0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (o_rw_valid && rw_ready) begin
        n_wr++; wa = o_rw_addr; wd = o_rw_data; ws = o_rw_strb;
      end
      if (o_b_valid && lite_b_ready) begin
        n_b++; br = o_b_resp; bid = o_b_id; bu = o_b_user;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (o_aw_ready !== 1'b1) begin fails++; $display("FAIL reset_aw_ready got %b exp 1", o_aw_ready); end
    tests++; if (o_w_ready !== 1'b1) begin fails++; $display("FAIL reset_w_ready got %b exp 1", o_w_ready); end
    tests++; if (o_b_valid !== 1'b0) begin fails++; $display("FAIL reset_b_valid got %b exp 0", o_b_valid); end
    tests++; if (o_rw_valid !== 1'b0) begin fails++; $display("FAIL reset_rw_valid got %b exp 0", o_rw_valid); end
    tests++; if (o_b_resp !== 2'b00) begin fails++; $display("FAIL reset_b_resp got %b exp 00", o_b_resp); end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    rw_ready = 1'b1; lite_b_ready = 1'b0;
    issue(1, 1, 1'b1, 8'h04, 1'b1, 32'hDEADBEEF, 4'hF, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL basic_accept got %b exp 1", ok); end
    @(negedge clk);
    tests++; if (o_rw_valid !== 1'b0) begin fails++; $display("FAIL basic_n1_rw_valid got %b exp 0", o_rw_valid); end
    tests++; if ({o_aw_ready, o_w_ready} !== 2'b00) begin fails++; $display("FAIL basic_n1_readies got %b exp 00", {o_aw_ready, o_w_ready}); end
    @(negedge clk);
    tests++; if (o_rw_valid !== 1'b1) begin fails++; $display("FAIL basic_n2_rw_valid got %b exp 1", o_rw_valid); end
    tests++; if (o_rw_addr !== 8'h04) begin fails++; $display("FAIL basic_rw_addr got %h exp 04", o_rw_addr); end
    tests++; if (o_rw_data !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_rw_data got %h exp deadbeef", o_rw_data); end
    tests++; if (o_rw_strb !== 4'hF) begin fails++; $display("FAIL basic_rw_strb got %h exp f", o_rw_strb); end
    @(negedge clk);
    tests++; if (o_b_valid !== 1'b1) begin fails++; $display("FAIL basic_b_valid got %b exp 1", o_b_valid); end
    tests++; if (o_b_resp !== 2'b00) begin fails++; $display("FAIL basic_b_resp got %b exp 00", o_b_resp); end
    tests++; if (o_b_id !== 1'b1) begin fails++; $display("FAIL basic_b_id got %b exp 1", o_b_id); end
    tests++; if (o_b_user !== 1'b1) begin fails++; $display("FAIL basic_b_user got %b exp 1", o_b_user); end
    tests++; if (o_rw_valid !== 1'b0) begin fails++; $display("FAIL basic_rw_done got %b exp 0", o_rw_valid); end
    lite_b_ready = 1'b1;
    @(posedge clk); #1;
    lite_b_ready = 1'b0;
    @(negedge clk);
    tests++; if (o_b_valid !== 1'b0) begin fails++; $display("FAIL basic_b_drop got %b exp 0", o_b_valid); end
  endtask

  task automatic test_w_first();
    bit ok;
    int early_wr, n_wr, n_b;
    logic [7:0] wa; logic [31:0] wd; logic [3:0] ws; logic [1:0] br; logic [0:0] bid, bu;
    rw_ready = 1'b1; lite_b_ready = 1'b1;
    issue(0, 1, 1'b0, 8'h00, 1'b0, 32'h12345678, 4'h3, ok);
    @(negedge clk);
    tests++; if ({o_aw_ready, o_w_ready} !== 2'b10) begin fails++; $display("FAIL wfirst_readies got %b exp 10", {o_aw_ready, o_w_ready}); end
    early_wr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (o_rw_valid || o_b_valid) early_wr++;
    end
    tests++; if (early_wr !== 0) begin fails++; $display("FAIL wfirst_early_activity got %0d exp 0", early_wr); end
    issue(1, 0, 1'b1, 8'h08, 1'b0, 32'h0, 4'h0, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL wfirst_aw_accept got %b exp 1", ok); end
    observe(10, n_wr, n_b, wa, wd, ws, br, bid, bu);
    tests++; if (n_wr !== 1) begin fails++; $display("FAIL wfirst_n_wr got %0d exp 1", n_wr); end
    tests++; if ({wa, wd, ws} !== {8'h08, 32'h12345678, 4'h3}) begin fails++; $display("FAIL wfirst_wr got %h/%h/%h exp 08/12345678/3", wa, wd, ws); end
    tests++; if (n_b !== 1) begin fails++; $display("FAIL wfirst_n_b got %0d exp 1", n_b); end
    tests++; if ({br, bid} !== {2'b00, 1'b1}) begin fails++; $display("FAIL wfirst_b got resp %b id %b exp 00/1", br, bid); end
    lite_b_ready = 1'b0;
  endtask

  task automatic test_slverr();
    bit ok;
    int n_wr, n_b;
    logic [7:0] wa; logic [31:0] wd; logic [3:0] ws; logic [1:0] br; logic [0:0] bid, bu;
    rw_ready = 1'b1; lite_b_ready = 1'b1;
    issue(1, 1, 1'b0, 8'h06, 1'b0, 32'hA5A5A5A5, 4'hF, ok);
    observe(8, n_wr, n_b, wa, wd, ws, br, bid, bu);
    tests++; if (n_wr !== 0) begin fails++; $display("FAIL slverr_n_wr got %0d exp 0", n_wr); end
    tests++; if (n_b !== 1) begin fails++; $display("FAIL slverr_n_b got %0d exp 1", n_b); end
    tests++; if (br !== 2'b10) begin fails++; $display("FAIL slverr_resp got %b exp 10", br); end
    lite_b_ready = 1'b0;
  endtask

  task automatic test_stall();
    bit ok;
    int bad;
    rw_ready = 1'b0; rw_err = 1'b0; lite_b_ready = 1'b0;
    issue(1, 1, 1'b1, 8'h0C, 1'b0, 32'hCAFEF00D, 4'hA, ok);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!o_rw_valid || o_rw_addr !== 8'h0C || o_rw_data !== 32'hCAFEF00D || o_rw_strb !== 4'hA) bad++;
      if (i == 5) begin rw_ready = 1'b1; rw_err = 1'b1; end
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL stall_stable_cycles got %0d bad exp 0", bad); end
    @(posedge clk); #1;
    rw_ready = 1'b0; rw_err = 1'b0;
    @(negedge clk);
    tests++; if (o_rw_valid !== 1'b0) begin fails++; $display("FAIL stall_rw_done got %b exp 0", o_rw_valid); end
    tests++; if (o_b_valid !== 1'b1) begin fails++; $display("FAIL stall_b_valid got %b exp 1", o_b_valid); end
    tests++; if (o_b_resp !== 2'b10) begin fails++; $display("FAIL stall_b_resp got %b exp 10", o_b_resp); end
    lite_b_ready = 1'b1;
    @(posedge clk); #1;
    lite_b_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad, n_wr, n_b;
    logic [7:0] wa; logic [31:0] wd; logic [3:0] ws; logic [1:0] br; logic [0:0] bid, bu;
    rw_ready = 1'b1; lite_b_ready = 1'b0;
    issue(1, 1, 1'b0, 8'h10, 1'b0, 32'h11111111, 4'hF, ok);
    repeat (3) @(negedge clk);
    issue(1, 1, 1'b1, 8'h14, 1'b1, 32'h22222222, 4'hC, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL b2b_accept_while_b_pending got %b exp 1", ok); end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (o_rw_valid || !o_b_valid || o_b_id !== 1'b0) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL b2b_hold_while_b_pending got %0d bad exp 0", bad); end
    lite_b_ready = 1'b1;
    @(posedge clk); #1;
    observe(10, n_wr, n_b, wa, wd, ws, br, bid, bu);
    tests++; if (n_wr !== 1) begin fails++; $display("FAIL b2b_n_wr got %0d exp 1", n_wr); end
    tests++; if ({wa, wd, ws} !== {8'h14, 32'h22222222, 4'hC}) begin fails++; $display("FAIL b2b_wr got %h/%h/%h exp 14/22222222/c", wa, wd, ws); end
    tests++; if (n_b !== 1) begin fails++; $display("FAIL b2b_n_b got %0d exp 1", n_b); end
    tests++; if ({br, bid, bu} !== {2'b00, 1'b1, 1'b1}) begin fails++; $display("FAIL b2b_second_b got %b/%b/%b exp 00/1/1", br, bid, bu); end
    lite_b_ready = 1'b0;
  endtask

  task automatic test_decode();
    bit ok;
    int n_wr, n_b;
    logic [7:0] wa; logic [31:0] wd; logic [3:0] ws; logic [1:0] br; logic [0:0] bid, bu;
    logic [7:0] addrs [5];
    logic [1:0] resps [5];
    int nwrs [5];
    logic [7:0] offs [5];
    addrs = '{8'h50, 8'h52, 8'h3C, 8'h44, 8'h4F};
    resps = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b10};
    nwrs  = '{0, 0, 0, 1, 0};
    offs  = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h00};
    sel = 1'b1; rw_ready = 1'b1; lite_b_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      issue(1, 1, 1'b0, addrs[k], 1'b0, 32'h0BADF00D, 4'hF, ok);
      observe(8, n_wr, n_b, wa, wd, ws, br, bid, bu);
      tests++; if (n_b !== 1 || br !== resps[k]) begin fails++; $display("FAIL decode_%h_b got n=%0d resp %b exp 1/%b", addrs[k], n_b, br, resps[k]); end
      tests++; if (n_wr !== nwrs[k] || wa !== offs[k]) begin fails++; $display("FAIL decode_%h_wr got n=%0d off %h exp %0d/%h", addrs[k], n_wr, wa, nwrs[k], offs[k]); end
    end
    lite_b_ready = 1'b0;
    @(posedge clk); #1;
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n_wr, n_b;
    logic [7:0] wa; logic [31:0] wd; logic [3:0] ws; logic [1:0] br; logic [0:0] bid, bu;
    rw_ready = 1'b0; lite_b_ready = 1'b1;
    issue(1, 1, 1'b1, 8'h20, 1'b1, 32'h55AA55AA, 4'hF, ok);
    repeat (2) @(negedge clk);
    tests++; if (o_rw_valid !== 1'b1) begin fails++; $display("FAIL midrst_in_write got %b exp 1", o_rw_valid); end
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    tests++; if (o_rw_valid !== 1'b0) begin fails++; $display("FAIL midrst_rw_valid got %b exp 0", o_rw_valid); end
    tests++; if ({o_aw_ready, o_w_ready} !== 2'b11) begin fails++; $display("FAIL midrst_readies got %b exp 11", {o_aw_ready, o_w_ready}); end
    rw_ready = 1'b1;
    observe(10, n_wr, n_b, wa, wd, ws, br, bid, bu);
    tests++; if ({n_wr, n_b} !== {32'd0, 32'd0}) begin fails++; $display("FAIL midrst_dropped got wr %0d b %0d exp 0/0", n_wr, n_b); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w_first();
    test_slverr();
    test_stall();
    test_back_to_back();
    test_decode();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
